fabric_reconfig_sequencer: RTL and testbench
============================================

// Module: fabric_reconfig_sequencer
// PURPOSE
// Sequences bitstream loads from SPI flash into the fabric: it issues start/slot to fabric_spi_controller
//   and monitors controller busy, the fabric_config busy/configured flags and the bitstream word stream.
// Performs the one-shot boot load, then serves runtime slot-reload requests one at a time.
// Verifies word count and configured flag after each load, retries, and reports done/error status.
// PARAMETERS
// NUM_SLOTS              16       flash slots addressable; SLOT_W = $clog2(NUM_SLOTS)
// BITSTREAM_LENGTH_WORDS 32'hEA2  expected 32-bit words per load
// BOOT_SLOT              0        slot loaded at boot
// MAX_RETRIES            2        reloads attempted after a failed check (0 = none)
// TIMEOUT_CYCLES         1<<20    watchdog limit per attempt (RECONFIG_WATCHDOG_EN only)
// PORTS
// clk_i              in   1       fabric clock
// rst_ni             in   1       synchronous, active-low reset
// boot_en_i          in   1       1 = controller mode; enables the one-shot boot load
// req_valid_i        in   1       runtime reload request
// req_slot_i         in   SLOT_W  requested slot
// req_ready_o        out  1       request accepted when valid & ready
// ctrl_start_o       out  1       1-cycle start pulse to SPI controller
// ctrl_slot_o        out  SLOT_W  slot to SPI controller; stable from START until IDLE
// ctrl_busy_i        in   1       SPI controller busy
// cfg_busy_i         in   1       fabric_config busy
// bitstream_valid_i  in   1       word strobe into fabric_config (monitored only)
// configured_i       in   1       fabric_config configured flag
// busy_o             out  1       sequencer not in IDLE
// done_o             out  1       1-cycle pulse on successful load
// error_o            out  1       sticky failure flag
// err_code_o         out  2       01 length mismatch, 10 not configured, 11 timeout
// word_count_o       out  32      words seen in last/current attempt, saturating at 32'hFFFF_FFFF
// BEHAVIOUR
// - All state and outputs registered. rst_ni low at a clk_i edge: state IDLE, all outputs 0,
//   boot_done, retry count and word count cleared. Reset mid-load aborts at once; ctrl_start_o is not
//   reissued until a new boot/request.
// - States: IDLE, START, WAIT_BUSY, LOAD, DRAIN, CHECK, ERROR.
// - IDLE: req_ready_o = 1 unless a boot is pending (boot_en_i=1 and boot_done=0).
//   A pending boot wins over a simultaneous request: slot = BOOT_SLOT, boot_done <= 1, req_ready_o = 0 that cycle.
//   Otherwise valid & ready latches req_slot_i. Either event clears error_o/err_code_o and retries,
//   then enters START next cycle. req_slot_i >= NUM_SLOTS clamps to NUM_SLOTS-1.
// - START: stays while ctrl_busy_i | cfg_busy_i. Otherwise pulses ctrl_start_o for exactly 1 cycle,
//   clears word_count, enters WAIT_BUSY.
// - WAIT_BUSY: on ctrl_busy_i = 1 -> LOAD. Words arriving here are counted.
// - LOAD: word_count += bitstream_valid_i (saturating). On ctrl_busy_i = 0 -> DRAIN.
// - DRAIN: keeps counting. On cfg_busy_i = 0 -> CHECK.
// - CHECK (1 cycle), first failing check decides err_code:
//     word_count == BITSTREAM_LENGTH_WORDS else 01; configured_i == 1 else 10.
//   Pass: done_o = 1 for 1 cycle -> IDLE.
//   Fail with retries < MAX_RETRIES: retries++ -> START. Fail otherwise: error_o = 1, err_code set -> ERROR.
// - ERROR: 1 cycle -> IDLE; error_o/err_code_o held until next accepted boot/request.
// - busy_o = (state != IDLE), registered with the state. ctrl_slot_o holds its last value in IDLE.
// - req_valid_i while busy: not accepted; requester must hold it (valid/ready handshake).
// CONFIGURATION
// - RECONFIG_WATCHDOG_EN defined: a cycle counter clears at START exit and runs in WAIT_BUSY/LOAD/DRAIN.
//   On reaching TIMEOUT_CYCLES: error_o = 1, err_code_o = 11 -> ERROR, no retry.
// - Undefined: no counter is instantiated, these states wait indefinitely and code 11 is never produced.
// TESTING
// - Boot: rst_ni 0->1, boot_en_i=1, model streams 32'hEA2 words, configured_i=1
//   -> exactly one ctrl_start_o, ctrl_slot_o=0, done_o pulse, word_count_o=32'hEA2, error_o=0.
// - Boot/request collision: boot pending and req_valid_i=1, slot 5, same cycle
//   -> boot slot 0 loads first; req accepted after done_o, second load uses slot 5.
// - Short stream: 32'hEA1 words, MAX_RETRIES=2 -> 3 start pulses, then error_o=1, err_code_o=01, busy_o=0.
// - Not configured: correct count, configured_i=0 on 1st attempt and 1 on 2nd -> 2 starts, done_o, error_o=0.
// - Watchdog (macro on, TIMEOUT_CYCLES=64): ctrl_busy_i never rises -> error_o=1, err_code_o=11 at cycle 64,
//   no retry. Macro off: still WAIT_BUSY after 1000 cycles.
// - Reset mid-LOAD: rst_ni=0 for 1 cycle at word 100 -> next cycle all outputs 0, state IDLE;
//   with boot_en_i=1 the boot load restarts from slot 0.

Source files
------------

// File: rtl/fabric_reconfig_sequencer_if.sv
// Runtime slot-reload request handshake between a requester and fabric_reconfig_sequencer.
// Master drives valid/slot, slave answers with ready.
interface fabric_reconfig_sequencer_if #(
  parameter int unsigned NUM_SLOTS = 16
);
  localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic              req_valid;
  logic [SLOT_W-1:0] req_slot;
  logic              req_ready;

  modport master (output req_valid, output req_slot, input req_ready);
  modport slave  (input req_valid, input req_slot, output req_ready);
endinterface

// File: rtl/fabric_reconfig_sequencer.sv
// Sequences boot and runtime bitstream loads, checks word count/configured flag, retries, reports.
// Optional per-attempt watchdog enabled by defining RECONFIG_WATCHDOG_EN.
module fabric_reconfig_sequencer #(
  parameter int unsigned  NUM_SLOTS              = 16,
  parameter logic [31:0]  BITSTREAM_LENGTH_WORDS = 32'hEA2,
  parameter int unsigned  BOOT_SLOT              = 0,
  parameter int unsigned  MAX_RETRIES            = 2,
  parameter int unsigned  TIMEOUT_CYCLES         = 1 << 20,
  localparam int unsigned SLOT_W                 = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      boot_en_i,
  fabric_reconfig_sequencer_if.slave req_if,
  output logic                      ctrl_start_o,
  output logic [SLOT_W-1:0]         ctrl_slot_o,
  input  logic                      ctrl_busy_i,
  input  logic                      cfg_busy_i,
  input  logic                      bitstream_valid_i,
  input  logic                      configured_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [1:0]                err_code_o,
  output logic [31:0]               word_count_o
);

  localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RetryW-1:0] MaxRetries = RetryW'(MAX_RETRIES);
  localparam logic [SLOT_W-1:0] BootSlot   = SLOT_W'(BOOT_SLOT);
  localparam logic [SLOT_W-1:0] MaxSlot    = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StWaitBusy, StLoad, StDrain, StCheck, StError
  } state_e;

  state_e            r_state, w_state_d;
  logic              r_boot_done, w_boot_done_d;
  logic [RetryW-1:0] r_retries, w_retries_d;
  logic [31:0]       r_word_count, w_word_count_d;
  logic [SLOT_W-1:0] r_slot, w_slot_d;
  logic              r_ctrl_start, w_ctrl_start_d;
  logic              r_req_ready, w_req_ready_d;
  logic              r_busy;
  logic              r_done, w_done_d;
  logic              r_error, w_error_d;
  logic [1:0]        r_err_code, w_err_code_d;
  logic              w_boot_pending, w_accept, w_in_attempt;

`ifdef RECONFIG_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdogW-1:0] r_wdog, w_wdog_d;
`endif

  always_comb begin
    w_state_d      = r_state;
    w_boot_done_d  = r_boot_done;
    w_retries_d    = r_retries;
    w_word_count_d = r_word_count;
    w_slot_d       = r_slot;
    w_ctrl_start_d = 1'b0;
    w_done_d       = 1'b0;
    w_error_d      = r_error;
    w_err_code_d   = r_err_code;

    w_boot_pending = boot_en_i & ~r_boot_done;
    // A pending boot always wins over a request presented in the same cycle.
    w_accept       = req_if.req_valid & r_req_ready & ~w_boot_pending;
    w_in_attempt   = (r_state == StWaitBusy) || (r_state == StLoad) || (r_state == StDrain);

    if (w_in_attempt && bitstream_valid_i && (r_word_count != 32'hFFFF_FFFF)) begin
      w_word_count_d = r_word_count + 32'd1;
    end

    case (r_state)
      StIdle: begin
        if (w_boot_pending || w_accept) begin
          w_error_d    = 1'b0;
          w_err_code_d = 2'b00;
          w_retries_d  = '0;
          w_state_d    = StStart;
          if (w_boot_pending) begin
            w_slot_d      = BootSlot;
            w_boot_done_d = 1'b1;
          end else if (32'(req_if.req_slot) >= NUM_SLOTS) begin
            w_slot_d = MaxSlot;
          end else begin
            w_slot_d = req_if.req_slot;
          end
        end
      end
      StStart: begin
        if (!(ctrl_busy_i || cfg_busy_i)) begin
          w_ctrl_start_d = 1'b1;
          w_word_count_d = '0;
          w_state_d      = StWaitBusy;
        end
      end
      StWaitBusy: if (ctrl_busy_i)  w_state_d = StLoad;
      StLoad:     if (!ctrl_busy_i) w_state_d = StDrain;
      StDrain:    if (!cfg_busy_i)  w_state_d = StCheck;
      StCheck: begin
        if ((r_word_count == BITSTREAM_LENGTH_WORDS) && configured_i) begin
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end else if (r_retries < MaxRetries) begin
          w_retries_d = r_retries + 1'b1;
          w_state_d   = StStart;
        end else begin
          w_error_d    = 1'b1;
          w_err_code_d = (r_word_count != BITSTREAM_LENGTH_WORDS) ? 2'b01 : 2'b10;
          w_state_d    = StError;
        end
      end
      StError: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

`ifdef RECONFIG_WATCHDOG_EN
    w_wdog_d = r_wdog;
    if (r_state == StStart) begin
      w_wdog_d = '0;
    end else if (w_in_attempt) begin
      w_wdog_d = r_wdog + 1'b1;
      // Timeout overrides any transition this cycle and skips the retry path.
      if (r_wdog == WdogW'(TIMEOUT_CYCLES - 1)) begin
        w_error_d    = 1'b1;
        w_err_code_d = 2'b11;
        w_state_d    = StError;
      end
    end
`endif

    w_req_ready_d = (w_state_d == StIdle) & ~(boot_en_i & ~w_boot_done_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= StIdle;
      r_boot_done  <= 1'b0;
      r_retries    <= '0;
      r_word_count <= '0;
      r_slot       <= '0;
      r_ctrl_start <= 1'b0;
      r_req_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      r_state      <= w_state_d;
      r_boot_done  <= w_boot_done_d;
      r_retries    <= w_retries_d;
      r_word_count <= w_word_count_d;
      r_slot       <= w_slot_d;
      r_ctrl_start <= w_ctrl_start_d;
      r_req_ready  <= w_req_ready_d;
      r_busy       <= (w_state_d != StIdle);
      r_done       <= w_done_d;
      r_error      <= w_error_d;
      r_err_code   <= w_err_code_d;
    end
  end

`ifdef RECONFIG_WATCHDOG_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_wdog <= '0;
    else         r_wdog <= w_wdog_d;
  end
`endif

  assign req_if.req_ready = r_req_ready;
  assign ctrl_start_o     = r_ctrl_start;
  assign ctrl_slot_o      = r_slot;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign error_o          = r_error;
  assign err_code_o       = r_err_code;
  assign word_count_o     = r_word_count;

endmodule

// File: tb/tb_fabric_reconfig_sequencer.sv
// Randomized bench: an SPI-controller/fabric_config model serves each start pulse while a
// reference model predicts attempts, done/error outcome and final word count per load.
module tb_fabric_reconfig_sequencer;

  localparam logic [31:0] LEN  = 32'hEA2;
  localparam int          MAXR = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        boot_en_i = 1'b0;
  logic        ctrl_busy_i = 1'b0;
  logic        cfg_busy_i = 1'b0;
  logic        bitstream_valid_i = 1'b0;
  logic        configured_i = 1'b0;
  logic        ctrl_start_o;
  logic [3:0]  ctrl_slot_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [1:0]  err_code_o;
  logic [31:0] word_count_o;

  int total = 0;
  int bad   = 0;
  int n_start = 0;
  int n_done  = 0;

  logic [31:0] att_cnt [3];
  bit          att_cfg [3];

  fabric_reconfig_sequencer_if #(.NUM_SLOTS(16)) req_if ();

  fabric_reconfig_sequencer #(
    .NUM_SLOTS             (16),
    .BITSTREAM_LENGTH_WORDS(LEN),
    .BOOT_SLOT             (0),
    .MAX_RETRIES           (MAXR),
    .TIMEOUT_CYCLES        (64)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .boot_en_i        (boot_en_i),
    .req_if           (req_if),
    .ctrl_start_o     (ctrl_start_o),
    .ctrl_slot_o      (ctrl_slot_o),
    .ctrl_busy_i      (ctrl_busy_i),
    .cfg_busy_i       (cfg_busy_i),
    .bitstream_valid_i(bitstream_valid_i),
    .configured_i     (configured_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .error_o          (error_o),
    .err_code_o       (err_code_o),
    .word_count_o     (word_count_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #1;
    if (ctrl_start_o === 1'b1) n_start <= n_start + 1;
    if (done_o === 1'b1)       n_done  <= n_done + 1;
  end

  // Outcome of one load from the per-attempt (word count, configured) table.
  function automatic void model_outcome(output int n_att, output bit ok,
                                        output logic [1:0] code, output logic [31:0] wc);
    n_att = 0; ok = 1'b0; code = 2'b00; wc = '0;
    for (int a = 0; a <= MAXR; a++) begin
      n_att = a + 1;
      wc    = att_cnt[a];
      if (att_cnt[a] == LEN && att_cfg[a]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) code = (wc != LEN) ? 2'b01 : 2'b10;
  endfunction

  task automatic apply_reset(input logic boot);
    @(negedge clk_i);
    rst_ni = 1'b0; boot_en_i = boot; ctrl_busy_i = 1'b0; cfg_busy_i = 1'b0;
    bitstream_valid_i = 1'b0; configured_i = 1'b0;
    req_if.req_valid = 1'b0; req_if.req_slot = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic serve_attempt(input logic [31:0] n, input bit cfg, input int gap_pct,
                               input logic [3:0] exp_slot);
    int t = 0;
    int sent = 0;
    while (ctrl_start_o !== 1'b1 && t < 64) begin @(negedge clk_i); t++; end
    total++;
    if (ctrl_start_o !== 1'b1) begin
      bad++; $display("FAIL start_timeout: start=%b after %0d cycles, want 1", ctrl_start_o, t);
      return;
    end
    total++;
    if (ctrl_slot_o !== exp_slot) begin
      bad++; $display("FAIL ctrl_slot: got %0d want %0d", ctrl_slot_o, exp_slot);
    end
    ctrl_busy_i = 1'b1; cfg_busy_i = 1'b1; configured_i = 1'b0;
    while (sent < n) begin
      if (int'($urandom_range(99)) >= gap_pct) begin bitstream_valid_i = 1'b1; sent++; end
      else bitstream_valid_i = 1'b0;
      @(negedge clk_i);
    end
    bitstream_valid_i = 1'b0; configured_i = cfg; ctrl_busy_i = 1'b0;
    @(negedge clk_i);
    cfg_busy_i = 1'b0;
  endtask

  task automatic run_load(input logic [3:0] exp_slot, input int gap_pct);
    int n_att; bit ok; logic [1:0] code; logic [31:0] wc;
    int s0, d0, t;
    logic [2:0] exp_err;
    model_outcome(n_att, ok, code, wc);
    exp_err = ok ? 3'b000 : {1'b1, code};
    s0 = n_start; d0 = n_done;
    for (int a = 0; a < n_att; a++) serve_attempt(att_cnt[a], att_cfg[a], gap_pct, exp_slot);
    t = 0;
    while (busy_o !== 1'b0 && t < 200) begin @(negedge clk_i); t++; end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL busy_end: got %b want 0", busy_o); end
    total++;
    if (n_start - s0 != n_att) begin
      bad++; $display("FAIL start_count: got %0d want %0d", n_start - s0, n_att);
    end
    total++;
    if (n_done - d0 != (ok ? 1 : 0)) begin
      bad++; $display("FAIL done_count: got %0d want %0d", n_done - d0, ok ? 1 : 0);
    end
    total++;
    if ({error_o, err_code_o} !== exp_err) begin
      bad++; $display("FAIL error_code: got %b%b want %b", error_o, err_code_o, exp_err);
    end
    total++;
    if (word_count_o !== wc) begin
      bad++; $display("FAIL word_count: got %0h want %0h", word_count_o, wc);
    end
  endtask

  task automatic issue_request(input logic [3:0] slot);
    int t = 0;
    req_if.req_valid = 1'b1; req_if.req_slot = slot;
    while (req_if.req_ready !== 1'b1 && t < 50) begin @(negedge clk_i); t++; end
    total++;
    if (req_if.req_ready !== 1'b1) begin
      bad++; $display("FAIL req_ready_timeout: got %b want 1", req_if.req_ready);
    end
    @(negedge clk_i);
    req_if.req_valid = 1'b0;
  endtask

  task automatic set_attempts(input logic [31:0] c0, c1, c2, input bit f0, f1, f2);
    att_cnt[0] = c0; att_cnt[1] = c1; att_cnt[2] = c2;
    att_cfg[0] = f0; att_cfg[1] = f1; att_cfg[2] = f2;
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    total++;
    if ({busy_o, done_o, error_o, err_code_o, word_count_o, ctrl_start_o, ctrl_slot_o,
         req_if.req_ready} !== '0) begin
      bad++; $display("FAIL reset_outputs: busy=%b done=%b err=%b code=%b wc=%0h start=%b slot=%0d rdy=%b want all 0",
                      busy_o, done_o, error_o, err_code_o, word_count_o, ctrl_start_o,
                      ctrl_slot_o, req_if.req_ready);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    total++;
    if ({busy_o, req_if.req_ready} !== 2'b01) begin
      bad++; $display("FAIL idle_ready: busy=%b ready=%b want 0 1", busy_o, req_if.req_ready);
    end
  endtask

  task automatic test_boot();
    apply_reset(1'b1);
    set_attempts(LEN, LEN, LEN, 1'b1, 1'b1, 1'b1);
    run_load(4'd0, 0);
  endtask

  task automatic test_collision();
    apply_reset(1'b1);
    req_if.req_valid = 1'b1; req_if.req_slot = 4'd5;
    set_attempts(LEN, LEN, LEN, 1'b1, 1'b1, 1'b1);
    run_load(4'd0, 0);
    total++;
    if (req_if.req_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_boot: got %b want 1", req_if.req_ready);
    end
    @(negedge clk_i);
    req_if.req_valid = 1'b0;
    run_load(4'd5, 0);
  endtask

  task automatic test_short_stream();
    logic [3:0] s = 4'($urandom_range(15));
    issue_request(s);
    set_attempts(LEN - 1, LEN - 1, LEN - 1, 1'b1, 1'b1, 1'b1);
    run_load(s, 0);
  endtask

  task automatic test_not_configured();
    logic [3:0] s = 4'($urandom_range(15));
    issue_request(s);
    set_attempts(LEN, LEN, LEN, 1'b0, 1'b1, 1'b1);
    run_load(s, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      logic [3:0] s = 4'($urandom_range(15));
      for (int a = 0; a < 3; a++) begin
        case ($urandom_range(3))
          0, 1:    att_cnt[a] = LEN;
          2:       att_cnt[a] = LEN - 1;
          default: att_cnt[a] = LEN + 1;
        endcase
        att_cfg[a] = ($urandom_range(3) != 0);
      end
      issue_request(s);
      run_load(s, 10);
    end
  endtask

  task automatic test_watchdog();
    int s0 = n_start;
    int t = 0;
    issue_request(4'd3);
`ifdef RECONFIG_WATCHDOG_EN
    while (error_o !== 1'b1 && t < 200) begin @(negedge clk_i); t++; end
    total++;
    if ({error_o, err_code_o} !== 3'b111) begin
      bad++; $display("FAIL watchdog_code: got %b%b want 111", error_o, err_code_o);
    end
    repeat (20) @(negedge clk_i);
    total++;
    if ({busy_o, n_start - s0} !== {1'b0, 32'd1}) begin
      bad++; $display("FAIL watchdog_no_retry: busy=%b starts=%0d want 0 1", busy_o, n_start - s0);
    end
`else
    repeat (1000) @(negedge clk_i);
    t = n_start - s0;
    total++;
    if ({busy_o, error_o, done_o} !== 3'b100 || t != 1) begin
      bad++; $display("FAIL wait_busy_hold: busy=%b err=%b done=%b starts=%0d want 1 0 0 1",
                      busy_o, error_o, done_o, t);
    end
`endif
  endtask

  task automatic test_reset_mid_load();
    int t = 0;
    apply_reset(1'b1);
    while (ctrl_start_o !== 1'b1 && t < 64) begin @(negedge clk_i); t++; end
    ctrl_busy_i = 1'b1; cfg_busy_i = 1'b1;
    for (int w = 0; w < 100; w++) begin bitstream_valid_i = 1'b1; @(negedge clk_i); end
    rst_ni = 1'b0; bitstream_valid_i = 1'b0; ctrl_busy_i = 1'b0; cfg_busy_i = 1'b0;
    @(negedge clk_i);
    total++;
    if ({busy_o, done_o, error_o, err_code_o, word_count_o, ctrl_start_o, ctrl_slot_o,
         req_if.req_ready} !== '0) begin
      bad++; $display("FAIL mid_load_reset: busy=%b wc=%0h start=%b want all 0",
                      busy_o, word_count_o, ctrl_start_o);
    end
    rst_ni = 1'b1;
    set_attempts(LEN, LEN, LEN, 1'b1, 1'b1, 1'b1);
    run_load(4'd0, 0);
  endtask

  initial begin
    req_if.req_valid = 1'b0;
    req_if.req_slot  = '0;
    test_reset();
    test_boot();
    test_collision();
    test_short_stream();
    test_not_configured();
    test_random();
    test_watchdog();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
